// File: rtl/secret_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : secret_pkg
//  Description : Shared constants and types for the secret_core accumulator IP.
//  Revision    : 1.0 - initial release
// ============================================================================
package secret_pkg;

    localparam int unsigned ACC_W        = 32;
    localparam logic [31:0] SECRET_VALUE = 32'd7;

    localparam int unsigned S1_W   = 1;
    localparam int unsigned S2_W   = 2;
    localparam int unsigned S8_W   = 8;
    localparam int unsigned S33_W  = 33;
    localparam int unsigned S64_W  = 64;
    localparam int unsigned S65_W  = 65;
    localparam int unsigned S129_W = 129;

    typedef logic [31:0]       acc_t;
    typedef logic [3:0][31:0]  s4x32_t;

endpackage : secret_pkg
`default_nettype wire

// File: rtl/secret_accum.sv
`default_nettype none
// ============================================================================
//  Module      : secret_accum
//  Description : Free-running accumulator with hidden additive constant and
//                a combinational bypass mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module secret_accum #(
    parameter int unsigned        ACC_W        = secret_pkg::ACC_W,
    parameter logic [ACC_W-1:0]   SECRET_VALUE = ACC_W'(secret_pkg::SECRET_VALUE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] accum_in,
    input  logic             accum_bypass,
    output logic [ACC_W-1:0] accum_out,
    output logic [ACC_W-1:0] accum_bypass_out
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_next;

    // Modulo-2^ACC_W sum; the carry out of the top bit is intentionally dropped.
    assign w_acc_next = r_acc + accum_in + SECRET_VALUE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

    assign accum_out        = r_acc;
    assign accum_bypass_out = accum_bypass ? accum_in : r_acc;

endmodule : secret_accum
`default_nettype wire

// File: rtl/secret_core.sv
`default_nettype none
// ============================================================================
//  Module      : secret_core
//  Description : Leaf IP: secret accumulator plus assorted-width pass-throughs.
//  Revision    : 1.0 - initial release
// ============================================================================
module secret_core #(
    parameter int unsigned        ACC_W        = secret_pkg::ACC_W,
    parameter logic [ACC_W-1:0]   SECRET_VALUE = ACC_W'(secret_pkg::SECRET_VALUE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ACC_W-1:0]              accum_in,
    output logic [ACC_W-1:0]              accum_out,
    input  logic                          accum_bypass,
    output logic [ACC_W-1:0]              accum_bypass_out,
    input  logic [secret_pkg::S1_W-1:0]   s1_in,
    output logic [secret_pkg::S1_W-1:0]   s1_out,
    input  logic [secret_pkg::S2_W-1:0]   s2_in,
    output logic [secret_pkg::S2_W-1:0]   s2_out,
    input  logic [secret_pkg::S8_W-1:0]   s8_in,
    output logic [secret_pkg::S8_W-1:0]   s8_out,
    input  logic [secret_pkg::S33_W-1:0]  s33_in,
    output logic [secret_pkg::S33_W-1:0]  s33_out,
    input  logic [secret_pkg::S64_W-1:0]  s64_in,
    output logic [secret_pkg::S64_W-1:0]  s64_out,
    input  logic [secret_pkg::S65_W-1:0]  s65_in,
    output logic [secret_pkg::S65_W-1:0]  s65_out,
    input  logic [secret_pkg::S129_W-1:0] s129_in,
    output logic [secret_pkg::S129_W-1:0] s129_out,
    input  secret_pkg::s4x32_t            s4x32_in,
    output secret_pkg::s4x32_t            s4x32_out
);

    import secret_pkg::*;

    secret_accum #(
        .ACC_W        (ACC_W),
        .SECRET_VALUE (SECRET_VALUE)
    ) u_accum (
        .clk              (clk),
        .rst              (rst),
        .accum_in         (accum_in),
        .accum_bypass     (accum_bypass),
        .accum_out        (accum_out),
        .accum_bypass_out (accum_bypass_out)
    );

    // Pure wiring: no registers and no reset dependence on these buses.
    assign s1_out    = s1_in;
    assign s2_out    = s2_in;
    assign s8_out    = s8_in;
    assign s33_out   = s33_in;
    assign s64_out   = s64_in;
    assign s65_out   = s65_in;
    assign s129_out  = s129_in;
    assign s4x32_out = s4x32_in;

endmodule : secret_core
`default_nettype wire

// File: tb/tb_secret_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_secret_core
//  Description : Self-checking bench for secret_core against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_secret_core;

    localparam logic [31:0] c_k = 32'd7;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   accum_in;
    logic [31:0]   accum_out;
    logic          accum_bypass;
    logic [31:0]   accum_bypass_out;
    logic          s1_in,   s1_out;
    logic [1:0]    s2_in,   s2_out;
    logic [7:0]    s8_in,   s8_out;
    logic [32:0]   s33_in,  s33_out;
    logic [63:0]   s64_in,  s64_out;
    logic [64:0]   s65_in,  s65_out;
    logic [128:0]  s129_in, s129_out;
    logic [3:0][31:0] s4x32_in, s4x32_out;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0]  r_model;
    logic [63:0]  r_lfsr;
    logic [511:0] r_pat;

    secret_core dut (
        .clk              (clk),
        .rst              (rst),
        .accum_in         (accum_in),
        .accum_out        (accum_out),
        .accum_bypass     (accum_bypass),
        .accum_bypass_out (accum_bypass_out),
        .s1_in            (s1_in),
        .s1_out           (s1_out),
        .s2_in            (s2_in),
        .s2_out           (s2_out),
        .s8_in            (s8_in),
        .s8_out           (s8_out),
        .s33_in           (s33_in),
        .s33_out          (s33_out),
        .s64_in           (s64_in),
        .s64_out          (s64_out),
        .s65_in           (s65_in),
        .s65_out          (s65_out),
        .s129_in          (s129_in),
        .s129_out         (s129_out),
        .s4x32_in         (s4x32_in),
        .s4x32_out        (s4x32_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check.
    task automatic cycle(input logic [31:0] din, input logic byp, input string tag);
        accum_in     = din;
        accum_bypass = byp;
        @(posedge clk);
        r_model = r_model + din + c_k;
        #1;
        check_eq({tag, "_acc"}, 160'(accum_out), 160'(r_model));
        check_eq({tag, "_byp"}, 160'(accum_bypass_out), 160'(byp ? din : r_model));
    endtask

    // Reset pulse between edges; output must clear before any clock edge.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        check_eq({tag, "_rst"}, 160'(accum_out), 160'(0));
        r_model = '0;
        #1;
        rst = 1'b0;
    endtask

    task automatic apply_pattern(input logic [511:0] pat, input string tag);
        s1_in    = pat[0];
        s2_in    = pat[1:0];
        s8_in    = pat[7:0];
        s33_in   = pat[32:0];
        s64_in   = pat[63:0];
        s65_in   = pat[64:0];
        s129_in  = pat[128:0];
        s4x32_in = pat[127:0];
        #1;
        check_eq({tag, "_s1"},   160'(s1_out),   160'(pat[0]));
        check_eq({tag, "_s2"},   160'(s2_out),   160'(pat[1:0]));
        check_eq({tag, "_s8"},   160'(s8_out),   160'(pat[7:0]));
        check_eq({tag, "_s33"},  160'(s33_out),  160'(pat[32:0]));
        check_eq({tag, "_s64"},  160'(s64_out),  160'(pat[63:0]));
        check_eq({tag, "_s65"},  160'(s65_out),  160'(pat[64:0]));
        check_eq({tag, "_s129"}, 160'(s129_out), 160'(pat[128:0]));
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s_s4x32_e%0d", tag, i), 160'(s4x32_out[i]), 160'(pat[i*32 +: 32]));
        end
    endtask

    initial begin
        rst          = 1'b1;
        accum_in     = '0;
        accum_bypass = 1'b0;
        r_model      = '0;
        apply_pattern('0, "pt_init");

        // Reset held across edges keeps the accumulator at zero.
        #2;
        check_eq("reset_now", 160'(accum_out), 160'(0));
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_held", 160'(accum_out), 160'(0));
        rst = 1'b0;

        cycle(32'd0, 1'b0, "first");
        check_eq("first_is_7", 160'(accum_out), 160'(32'd7));
        cycle(32'd5, 1'b0, "second");
        check_eq("second_is_19", 160'(accum_out), 160'(32'd19));

        // Running sum from zero.
        async_reset("sum");
        for (int i = 0; i < 3; i++) begin
            cycle(32'd100 + 32'(5 * i), 1'b0, $sformatf("sum%0d", i));
        end
        check_eq("sum_is_336", 160'(accum_out), 160'(32'd336));

        // Bypass is combinational and does not disturb accumulation.
        accum_in     = 32'h1234;
        accum_bypass = 1'b1;
        #1;
        check_eq("bypass_now", 160'(accum_bypass_out), 160'(32'h1234));
        cycle(32'h1234, 1'b1, "bypass_run");
        accum_bypass = 1'b0;
        #1;
        check_eq("bypass_off", 160'(accum_bypass_out), 160'(r_model));

        // Wrap-around.
        async_reset("wrap");
        cycle(32'hFFFF_FFE9, 1'b0, "wrap_pre");
        check_eq("wrap_pre_val", 160'(accum_out), 160'(32'hFFFF_FFF0));
        cycle(32'd9, 1'b0, "wrap");
        check_eq("wrap_zero", 160'(accum_out), 160'(32'h0));

        // Asynchronous reset mid-run.
        async_reset("mid_pre");
        cycle(32'h4E, 1'b0, "mid_load");
        check_eq("mid_is_55", 160'(accum_out), 160'(32'h55));
        async_reset("mid");
        cycle(32'h20, 1'b0, "mid_post");
        check_eq("mid_post_27", 160'(accum_out), 160'(32'h27));

        // Randomized accumulate/bypass traffic with sporadic resets.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                async_reset($sformatf("rnd%0d", i));
            end
            cycle($urandom, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
            accum_bypass = ~accum_bypass;
            #1;
            check_eq($sformatf("rnd%0d_tog", i), 160'(accum_bypass_out),
                     160'(accum_bypass ? accum_in : r_model));
        end

        // Pass-throughs: all-ones, LFSR-derived, then random; reset has no effect.
        apply_pattern({512{1'b1}}, "pt_ones");
        r_lfsr = 64'h15AE_F0C8_DD70_A449;
        for (int i = 0; i < 6; i++) begin
            r_pat = {8{r_lfsr}};
            apply_pattern(r_pat, $sformatf("pt_lfsr%0d", i));
            r_lfsr = (r_lfsr >> 1) ^ (r_lfsr[0] ? 64'hD800_0000_0000_0000 : 64'h0);
        end
        rst = 1'b1;
        for (int w = 0; w < 16; w++) begin
            r_pat[w*32 +: 32] = $urandom;
        end
        apply_pattern(r_pat, "pt_rand_rst");
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_secret_core
`default_nettype wire
